// File: rtl/xor_seq_ctrl_if.sv
// rtl/xor_seq_ctrl_if.sv - operand/result bus between the XOR sequencer and the shared neuron
interface xor_seq_ctrl_if #(
  parameter int TAM = 16
);
  logic                nrn_req;
  logic [3:0][TAM-1:0] nrn_in1;
  logic [3:0][TAM-1:0] nrn_in2;
  logic [TAM-1:0]      nrn_w0;
  logic [TAM-1:0]      nrn_w1;
  logic [TAM-1:0]      nrn_w2;
  logic                nrn_ack;
  logic [3:0][TAM-1:0] nrn_res;

  // Sequencer side: presents operands, receives the neuron result.
  modport master (
    output nrn_req, nrn_in1, nrn_in2, nrn_w0, nrn_w1, nrn_w2,
    input  nrn_ack, nrn_res
  );

  // Neuron side: consumes operands, returns the result.
  modport slave (
    input  nrn_req, nrn_in1, nrn_in2, nrn_w0, nrn_w1, nrn_w2,
    output nrn_ack, nrn_res
  );
endinterface

// File: rtl/xor_seq_ctrl.sv
// rtl/xor_seq_ctrl.sv - sequences three passes through a shared neuron to evaluate XOR
module xor_seq_ctrl #(
  parameter int TAM     = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0][TAM-1:0] in1,
  input  logic [3:0][TAM-1:0] in2,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [TAM-1:0]      cfg_data,
  xor_seq_ctrl_if.master      nrn,
  output logic [3:0][TAM-1:0] result,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                cfg_err
);

  // Wide enough to hold TIMEOUT itself; at least one bit.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Z1   = 3'd1,
    Z2   = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TAM-1:0]      wgt [9];
  logic [3:0][TAM-1:0] in1_q;
  logic [3:0][TAM-1:0] in2_q;
  logic [3:0][TAM-1:0] z1_q;
  logic [3:0][TAM-1:0] z2_q;
  logic [3:0][TAM-1:0] result_q;
  logic [CW-1:0]       wait_cnt;
  logic                waiting;
  logic                ack_ok;
  logic                timeout;
  logic                start_ok;

  // Only the three neuron phases listen to the acknowledge.
  assign waiting  = (state == Z1) || (state == Z2) || (state == OUT);
  assign ack_ok   = waiting && nrn.nrn_ack;
  assign timeout  = waiting && !nrn.nrn_ack && (wait_cnt == CW'(TIMEOUT));
  assign start_ok = (state == IDLE) && start;
  assign result   = result_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: each phase advances on ack or bails to DONE on timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = Z1;
      Z1: begin
        if (nrn.nrn_ack)  state_nxt = Z2;
        else if (timeout) state_nxt = DONE;
      end
      Z2: begin
        if (nrn.nrn_ack)  state_nxt = OUT;
        else if (timeout) state_nxt = DONE;
      end
      OUT: begin
        if (nrn.nrn_ack || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: operand/weight mux per phase, zeros outside the neuron phases.
  always_comb begin
    nrn.nrn_req = 1'b0;
    nrn.nrn_in1 = '0;
    nrn.nrn_in2 = '0;
    nrn.nrn_w0  = '0;
    nrn.nrn_w1  = '0;
    nrn.nrn_w2  = '0;
    busy        = (state != IDLE);
    done        = (state == DONE);
    case (state)
      Z1: begin
        nrn.nrn_req = 1'b1;
        nrn.nrn_in1 = in1_q;
        nrn.nrn_in2 = in2_q;
        nrn.nrn_w0  = wgt[0];
        nrn.nrn_w1  = wgt[1];
        nrn.nrn_w2  = wgt[2];
      end
      Z2: begin
        nrn.nrn_req = 1'b1;
        nrn.nrn_in1 = in1_q;
        nrn.nrn_in2 = in2_q;
        nrn.nrn_w0  = wgt[3];
        nrn.nrn_w1  = wgt[4];
        nrn.nrn_w2  = wgt[5];
      end
      OUT: begin
        nrn.nrn_req = 1'b1;
        nrn.nrn_in1 = z1_q;
        nrn.nrn_in2 = z2_q;
        nrn.nrn_w0  = wgt[6];
        nrn.nrn_w1  = wgt[7];
        nrn.nrn_w2  = wgt[8];
      end
      default: ;
    endcase
  end

  // Weight file: writable only in IDLE; anything else is refused and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) wgt[i] <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (start_ok) cfg_err <= 1'b0;
      // A refused write in the same cycle as start still leaves the flag set.
      if (cfg_we) begin
        if ((state == IDLE) && (cfg_addr < 4'd9)) wgt[cfg_addr] <= cfg_data;
        else                                      cfg_err <= 1'b1;
      end
    end
  end

  // Sample latch on accepted start; error flag cleared by start, set by timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1_q <= '0;
      in2_q <= '0;
      err   <= 1'b0;
    end else begin
      if (start_ok) begin
        in1_q <= in1;
        in2_q <= in2;
        err   <= 1'b0;
      end
      if (timeout) err <= 1'b1;
    end
  end

  // Wait counter: zero on any phase change, counts cycles spent without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!waiting || (state_nxt != state)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Result capture: z1, z2 and the final result each load on their phase's ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z1_q     <= '0;
      z2_q     <= '0;
      result_q <= '0;
    end else if (ack_ok) begin
      case (state)
        Z1:      z1_q     <= nrn.nrn_res;
        Z2:      z2_q     <= nrn.nrn_res;
        OUT:     result_q <= nrn.nrn_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_seq_ctrl.sv
// tb/tb_xor_seq_ctrl.sv - self-checking bench for xor_seq_ctrl
module tb_xor_seq_ctrl;
  localparam int TAM     = 16;
  localparam int TIMEOUT = 4;

  logic                clk      = 1'b0;
  logic                rst_n    = 1'b0;
  logic                start    = 1'b0;
  logic                cfg_we   = 1'b0;
  logic [3:0]          cfg_addr = '0;
  logic [TAM-1:0]      cfg_data = '0;
  logic [3:0][TAM-1:0] in1      = '0;
  logic [3:0][TAM-1:0] in2      = '0;
  logic [3:0][TAM-1:0] result;
  logic                busy;
  logic                done;
  logic                err;
  logic                cfg_err;

  xor_seq_ctrl_if #(.TAM(TAM)) nrn_bus ();

  xor_seq_ctrl #(.TAM(TAM), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .nrn      (nrn_bus),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Neuron model: 0 = zero latency, 1 = ack on 4th cycle of a phase, 2 = never, 3 = manual.
  int          mode    = 0;
  bit          fn      = 1'b0;
  logic        man_ack = 1'b0;
  logic [63:0] man_res = '0;
  logic [3:0]  dcnt    = '0;
  logic        ack_m;
  logic [63:0] res_m;

  // fn=0: lane-wise a^b; fn=1: lane-wise (a+b)^w0, so each pass leaves a visible mark.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [15:0] w0, input bit f);
    logic [63:0] r;
    logic [15:0] s;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      s = a[l*16 +: 16] + b[l*16 +: 16];
      r[l*16 +: 16] = f ? (s ^ w0) : (a[l*16 +: 16] ^ b[l*16 +: 16]);
    end
    return r;
  endfunction

  always_comb begin
    ack_m = 1'b0;
    res_m = model(nrn_bus.nrn_in1, nrn_bus.nrn_in2, nrn_bus.nrn_w0, fn);
    case (mode)
      0: ack_m = nrn_bus.nrn_req;
      1: ack_m = nrn_bus.nrn_req && (dcnt == 4'd3);
      3: begin
        ack_m = man_ack;
        res_m = man_res;
      end
      default: ack_m = 1'b0;
    endcase
  end

  assign nrn_bus.nrn_ack = ack_m;
  assign nrn_bus.nrn_res = res_m;

  always @(posedge clk) dcnt <= (!nrn_bus.nrn_req || ack_m) ? 4'd0 : dcnt + 4'd1;

  // Passive monitor, sampled on the falling edge.
  logic [63:0] wlog [1024];
  int          widx     = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          rchg     = 0;
  logic [63:0] prev_res = '0;
  logic [63:0] out_in1  = '0;

  always @(negedge clk) begin
    if (nrn_bus.nrn_req) begin
      wlog[widx % 1024] <= {16'h0, nrn_bus.nrn_w0, nrn_bus.nrn_w1, nrn_bus.nrn_w2};
      widx <= widx + 1;
    end
    if (nrn_bus.nrn_req && nrn_bus.nrn_w0 == 16'd7) out_in1 <= nrn_bus.nrn_in1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (result != prev_res) rchg <= rchg + 1;
    prev_res <= result;
  end

  int checks   = 0;
  int failures = 0;
  int s_w, s_done, s_busy, s_rchg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_w    = widx;
    s_done = done_cnt;
    s_busy = busy_cnt;
    s_rchg = rchg;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic load_weights();
    for (int i = 0; i < 9; i++) wr(4'(i), 16'(i + 1));
  endtask

  task automatic kick(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cycles counts rising edges from the one that accepted start to DONE entry.
  task automatic wait_done(input int budget, output int cycles, output bit found);
    cycles = 1;
    found  = 1'b0;
    while (!found && cycles <= budget) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    if (found) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end else begin
      cycles = 0;
    end
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b, input int budget,
                     output int cycles);
    bit f;
    snap();
    kick(a, b);
    wait_done(budget, cycles, f);
  endtask

  task automatic check_wseq(input string name);
    for (int k = 0; k < 3; k++)
      check(name, wlog[(s_w + k) % 1024],
            {16'h0, 16'(3 * k + 1), 16'(3 * k + 2), 16'(3 * k + 3)});
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [63:0] z1;
  } vec_t;

  vec_t tbl [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit found;

    // Expected values under fn=1 with weights 1..9: z1=(a+b)^1, z2=(a+b)^4, res=(z1+z2)^7.
    tbl[0] = '{64'h0001_0010_FFFF_0100, 64'h0002_0005_0001_0003,
               64'h000E_0022_0002_020E, 64'h0002_0014_0001_0102};
    tbl[1] = '{64'h0000_8000_0007_0001, 64'h0000_8000_0000_0002,
               64'h0002_0002_000E_000E, 64'h0001_0001_0006_0002};
    tbl[2] = '{64'h0010_0007_0000_0100, 64'h0005_0000_0000_0003,
               64'h0022_000E_0002_020E, 64'h0014_0006_0001_0102};

    #2;
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_done",    64'(done), 64'd0);
    check("rst_err",     64'(err), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_req",     64'(nrn_bus.nrn_req), 64'd0);
    check("rst_result",  result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_weights();

    // Zero-latency XOR neuron.
    mode = 0;
    fn   = 1'b0;
    run(64'h0000_0001_0000_0001, 64'h0000_0000_0001_0001, 20, cyc);
    check("zl_cycles", 64'(cyc), 64'd4);
    check("zl_busy",   64'(busy_cnt - s_busy), 64'd4);
    check("zl_done",   64'(done_cnt - s_done), 64'd1);
    check("zl_nreq",   64'(widx - s_w), 64'd3);
    check_wseq("zl_wseq");
    check("zl_result", result, 64'd0);

    // Table of vectors with the additive neuron.
    fn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run(tbl[i].a, tbl[i].b, 20, cyc);
      check($sformatf("tbl%0d_cycles", i), 64'(cyc), 64'd4);
      check($sformatf("tbl%0d_result", i), result, tbl[i].res);
      check($sformatf("tbl%0d_z1", i), out_in1, tbl[i].z1);
    end

    // Ack delayed three cycles in every phase.
    mode = 1;
    run(tbl[0].a, tbl[0].b, 40, cyc);
    check("dly_cycles", 64'(cyc), 64'd13);
    check("dly_result", result, tbl[0].res);
    check("dly_rchg",   64'(rchg - s_rchg), 64'd1);
    check("dly_busy",   64'(busy_cnt - s_busy), 64'd13);

    // Neuron never acks: timeout out of Z1.
    mode = 2;
    run(tbl[1].a, tbl[1].b, 30, cyc);
    check("to_cycles", 64'(cyc), 64'(TIMEOUT + 2));
    check("to_err",    64'(err), 64'd1);
    check("to_result", result, tbl[0].res);
    check("to_rchg",   64'(rchg - s_rchg), 64'd0);
    check("to_nreq",   64'(widx - s_w), 64'(TIMEOUT + 1));
    check("to_done",   64'(done_cnt - s_done), 64'd1);
    mode = 0;
    run(tbl[1].a, tbl[1].b, 20, cyc);
    check("to_next_err",    64'(err), 64'd0);
    check("to_next_result", result, tbl[1].res);

    // Config write and start while busy, both in Z2.
    mode = 1;
    snap();
    kick(tbl[0].a, tbl[0].b);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (nrn_bus.nrn_req && nrn_bus.nrn_w0 == 16'd4) found = 1'b1;
    end
    check("busy_reach_z2", 64'(found), 64'd1);
    cfg_we   = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = 16'hBEEF;
    start    = 1'b1;
    in1      = tbl[1].a;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    start  = 1'b0;
    wait_done(40, cyc, found);
    check("busy_found",   64'(found), 64'd1);
    @(negedge clk);
    #1;
    check("busy_done",    64'(done_cnt - s_done), 64'd1);
    check("busy_busycnt", 64'(busy_cnt - s_busy), 64'd13);
    check("busy_cfg_err", 64'(cfg_err), 64'd1);
    check("busy_result",  result, tbl[0].res);
    check("busy_idle",    64'(busy), 64'd0);
    mode = 0;
    run(tbl[0].a, tbl[0].b, 20, cyc);
    check_wseq("busy_wseq");
    check("busy_cfg_clr", 64'(cfg_err), 64'd0);
    wr(4'd12, 16'hBEEF);
    check("badaddr_cfg_err", 64'(cfg_err), 64'd1);
    run(tbl[0].a, tbl[0].b, 20, cyc);
    check_wseq("badaddr_wseq");
    check("badaddr_result", result, tbl[0].res);

    // Reset asserted during OUT.
    mode = 1;
    snap();
    kick(tbl[1].a, tbl[1].b);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (nrn_bus.nrn_req && nrn_bus.nrn_w0 == 16'd7) found = 1'b1;
    end
    check("mrst_reach_out", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_req",    64'(nrn_bus.nrn_req), 64'd0);
    check("mrst_busy",   64'(busy), 64'd0);
    check("mrst_done",   64'(done), 64'd0);
    check("mrst_result", result, 64'd0);
    check("mrst_in1",    nrn_bus.nrn_in1, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mrst_no_done", 64'(done_cnt - s_done), 64'd0);
    load_weights();
    mode = 0;
    run(tbl[2].a, tbl[2].b, 20, cyc);
    check("mrst_cycles", 64'(cyc), 64'd4);
    check("mrst_done1",  64'(done_cnt - s_done), 64'd1);
    check_wseq("mrst_wseq");
    check("mrst_res2",   result, tbl[2].res);

    // Spurious ack in IDLE coinciding with start.
    mode = 3;
    @(negedge clk);
    in1     = tbl[0].a;
    in2     = tbl[0].b;
    start   = 1'b1;
    man_ack = 1'b1;
    man_res = 64'hDEAD_DEAD_DEAD_DEAD;
    @(posedge clk);
    #1;
    start   = 1'b0;
    man_ack = 1'b0;
    @(negedge clk);
    check("spur_z1_a", 64'(nrn_bus.nrn_w0), 64'd1);
    @(negedge clk);
    check("spur_z1_b", 64'(nrn_bus.nrn_w0), 64'd1);
    man_res = 64'h1111_2222_3333_4444;
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    mode    = 0;
    wait_done(20, cyc, found);
    check("spur_found", 64'(found), 64'd1);
    check("spur_z1",    out_in1, 64'h1111_2222_3333_4444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
